window_scan_ctrl: RTL and testbench

- Frame-level sequencer for the 7x7 window datapath (per-row 7-tap window registers plus 6 line buffers) in the SIFT dominant-orientation stage.
- Tracks the raster pixel coordinate of the incoming stream and generates shift enables for the window/line-buffer chain.
- Flags the cycles in which the 7x7 window is fully inside the image and reports the centre coordinate of that window.
- Produces the frame-done pulse and protocol-error indications for the downstream orientation histogram.

---
 rtl/sift_win_pkg.sv | 23 ++
 rtl/raster_xy_counter.sv | 61 ++++++
 rtl/window_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_window_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_win_pkg.sv
// rtl/sift_win_pkg.sv - shared constants, FSM state type and helpers for the 7x7 window sequencer
//
// Purpose : default window geometry, frame sequencer state encoding and the
//           windows-per-frame helper used by the window scan controller and its users.
// Contents: WIN, HALF, state_t, windows_per_frame()
package sift_win_pkg;

  localparam int WIN  = 7;
  localparam int HALF = (WIN - 1) / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of fully-inside window positions in an img_w x img_h frame.
  function automatic int windows_per_frame(input int img_w, input int img_h, input int win);
    return (img_w - win + 1) * (img_h - win + 1);
  endfunction

endpackage

// File: rtl/raster_xy_counter.sv
// rtl/raster_xy_counter.sv - raster-order x/y pixel counter with enable, sync clear and wrap flags
//
// Purpose : holds the coordinate of the next pixel in raster order.
// Ports   : clk_i, rst_ni   - clock, synchronous active-low reset
//           clr_i           - restart: the pixel presented this cycle is (0,0)
//           en_i            - advance past the current pixel
//           x_o, y_o        - coordinate of the current pixel
//           x_last_o        - x_o is the last column
//           y_last_o        - y_o is the last row
module raster_xy_counter #(
  parameter int W   = 640,
  parameter int H   = 480,
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           x_last_o,
  output logic           y_last_o
);

  logic [X_W-1:0] x_q, x_d, x_base;
  logic [Y_W-1:0] y_q, y_d, y_base;

  // A clear combined with an enable means "this pixel is (0,0), step past it",
  // so the clear only rebases the position the increment starts from.
  always_comb begin
    x_base = clr_i ? '0 : x_q;
    y_base = clr_i ? '0 : y_q;
    x_d    = x_base;
    y_d    = y_base;
    if (en_i) begin
      if (x_base == X_W'(W - 1)) begin
        x_d = '0;
        y_d = (y_base == Y_W'(H - 1)) ? '0 : y_base + Y_W'(1);
      end else begin
        x_d = x_base + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign x_last_o = (x_q == X_W'(W - 1));
  assign y_last_o = (y_q == Y_W'(H - 1));

endmodule

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - frame sequencer for the 7x7 window / line-buffer datapath
//
// Purpose : tracks the raster position of the pixel stream, drives the window
//           shift enable, flags complete windows with their centre coordinate,
//           and reports frame end and restart errors.
// Ports   : iclk, irst_n            - clock, synchronous active-low reset
//           ivalid, isof, oin_ready - upstream pixel handshake (isof marks pixel (0,0))
//           iready                  - downstream histogram ready
//           oshift_en               - accepted pixel, shift the window chain
//           owin_valid, ocenter_x/y - registered window strobe and centre
//           oframe_done, oerr       - one-cycle frame end / restart-error pulses
//           owin_cnt                - windows emitted in the current or last frame
//           obusy                   - a frame is in progress
module window_scan_ctrl
  import sift_win_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = sift_win_pkg::WIN,
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int CNT_W = 19
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             ivalid,
  input  logic             isof,
  input  logic             iready,
  output logic             oin_ready,
  output logic             oshift_en,
  output logic             owin_valid,
  output logic [X_W-1:0]   ocenter_x,
  output logic [Y_W-1:0]   ocenter_y,
  output logic             oframe_done,
  output logic             oerr,
  output logic [CNT_W-1:0] owin_cnt,
  output logic             obusy
);

  // Offset from the bottom-right pixel of a window to its centre.
  localparam int C_OFS = (WIN - 1) / 2;

  state_t           state_q, state_d;
  logic             acc, restart;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             x_last, y_last;

  logic             win_q, win_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    oin_ready = 1'b0;
    case (state_q)
      IDLE:          oin_ready = 1'b1;
      PRIME, ACTIVE: oin_ready = iready;
      default:       oin_ready = 1'b0;
    endcase
  end

  assign acc       = ivalid & oin_ready;
  // Any accepted start-of-frame pixel restarts at (0,0), whatever the state.
  assign restart   = acc & isof;
  // Pixels arriving in IDLE without start-of-frame are dropped, not shifted in.
  assign oshift_en = acc & ((state_q != IDLE) | isof);

  raster_xy_counter #(
    .W   (IMG_W),
    .H   (IMG_H),
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_xy (
    .clk_i    (iclk),
    .rst_ni   (irst_n),
    .clr_i    (restart),
    .en_i     (oshift_en),
    .x_o      (x),
    .y_o      (y),
    .x_last_o (x_last),
    .y_last_o (y_last)
  );

  always_comb begin
    state_d = state_q;
    win_d   = 1'b0;
    cx_d    = cx_q;
    cy_d    = cy_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (restart) state_d = PRIME;
      end
      PRIME: begin
        if (restart)                                           state_d = PRIME;
        else if (acc && x_last && (y == Y_W'(WIN - 2)))        state_d = ACTIVE;
      end
      ACTIVE: begin
        // A start-of-frame on the final pixel is a restart, not a frame end.
        if (restart)                                           state_d = PRIME;
        else if (acc && x_last && y_last)                      state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // In ACTIVE every row is at least WIN-1, so only the column decides.
    if ((state_q == ACTIVE) && acc && !isof && (x >= X_W'(WIN - 1))) begin
      win_d = 1'b1;
      cx_d  = x - X_W'(C_OFS);
      cy_d  = y - Y_W'(C_OFS);
    end

    if (restart) begin
      err_d = (state_q != IDLE);
      cnt_d = '0;
    end else if (win_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owin_valid  = win_q;
  assign ocenter_x   = cx_q;
  assign ocenter_y   = cy_q;
  assign oframe_done = done_q;
  assign oerr        = err_q;
  assign owin_cnt    = cnt_q;
  assign obusy       = (state_q != IDLE);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - randomized scoreboard bench for window_scan_ctrl
module tb_window_scan_ctrl;

  localparam int W  = 10;
  localparam int H  = 8;
  localparam int WN = 7;
  localparam int HF = 3;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int CW = 8;

  typedef struct { int cyc; int cx; int cy; int cnt; } win_t;
  typedef struct { int cyc; int cnt; } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (10x8)
  logic          rst_n, ivalid, isof, iready;
  logic          oin_ready, oshift_en, owin_valid, oframe_done, oerr, obusy;
  logic [XW-1:0] ocenter_x;
  logic [YW-1:0] ocenter_y;
  logic [CW-1:0] owin_cnt;

  // secondary DUT (7x7)
  logic          rst7_n, v7, s7, r7;
  logic          rdy7, sh7, wv7, fd7, er7, bz7;
  logic [2:0]    cx7o, cy7o;
  logic [5:0]    cnt7o;

  window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(WN), .X_W(XW), .Y_W(YW), .CNT_W(CW)) dut (
    .iclk(clk), .irst_n(rst_n), .ivalid(ivalid), .isof(isof), .iready(iready),
    .oin_ready(oin_ready), .oshift_en(oshift_en), .owin_valid(owin_valid),
    .ocenter_x(ocenter_x), .ocenter_y(ocenter_y), .oframe_done(oframe_done),
    .oerr(oerr), .owin_cnt(owin_cnt), .obusy(obusy)
  );

  window_scan_ctrl #(.IMG_W(7), .IMG_H(7), .WIN(7), .X_W(3), .Y_W(3), .CNT_W(6)) dut7 (
    .iclk(clk), .irst_n(rst7_n), .ivalid(v7), .isof(s7), .iready(r7),
    .oin_ready(rdy7), .oshift_en(sh7), .owin_valid(wv7),
    .ocenter_x(cx7o), .ocenter_y(cy7o), .oframe_done(fd7),
    .oerr(er7), .owin_cnt(cnt7o), .obusy(bz7)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   done7 = 0;
  int   shift_cnt = 0;

  win_t wq[$];
  evt_t dq[$];
  evt_t eq[$];

  // reference model state: frame in progress, one-cycle gap after frame end,
  // index of the last accepted pixel, windows counted in this frame
  bit m_inframe = 0;
  bit m_gap = 0;
  int m_p = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: registered outputs, sampled just after each rising edge
  always @(posedge clk) begin
    bit ew, ed, ee;
    cyc++;
    #2;
    if (mon_en) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
      while (dq.size() > 0 && dq[0].cyc < cyc) void'(dq.pop_front());
      while (eq.size() > 0 && eq[0].cyc < cyc) void'(eq.pop_front());
      ew = (wq.size() > 0) && (wq[0].cyc == cyc);
      ed = (dq.size() > 0) && (dq[0].cyc == cyc);
      ee = (eq.size() > 0) && (eq[0].cyc == cyc);
      chk("win_valid", int'(owin_valid), int'(ew));
      chk("frame_done", int'(oframe_done), int'(ed));
      chk("err", int'(oerr), int'(ee));
      if (ew && owin_valid) begin
        chk("center_x", int'(ocenter_x), wq[0].cx);
        chk("center_y", int'(ocenter_y), wq[0].cy);
        chk("win_cnt", int'(owin_cnt), wq[0].cnt);
        void'(wq.pop_front());
      end
      if (ed && oframe_done) begin
        chk("done_cnt", int'(owin_cnt), dq[0].cnt);
        void'(dq.pop_front());
      end
      if (ee && oerr) begin
        chk("err_cnt", int'(owin_cnt), 0);
        void'(eq.pop_front());
      end
    end
  end

  // Frame-level model: a frame is W*H raster pixels counted from a start-of-frame;
  // windows exist where both coordinates are at least WN-1.
  task automatic model_step(input bit acc, input bit s);
    int   p, x, y;
    bit   use_px;
    win_t w;
    evt_t e;
    use_px = 0;
    p = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (acc) begin
      if (s) begin
        if (m_inframe) begin
          e.cyc = cyc + 1; e.cnt = 0;
          eq.push_back(e);
        end
        m_inframe = 1; m_cnt = 0; p = 0; use_px = 1;
      end else if (m_inframe) begin
        p = m_p + 1; use_px = 1;
      end
    end
    if (use_px) begin
      m_p = p;
      x = p % W;
      y = p / W;
      if (x >= WN - 1 && y >= WN - 1) begin
        m_cnt++;
        w.cyc = cyc + 1; w.cx = x - HF; w.cy = y - HF; w.cnt = m_cnt;
        wq.push_back(w);
      end
      if (p == W * H - 1) begin
        e.cyc = cyc + 1; e.cnt = m_cnt;
        dq.push_back(e);
        m_inframe = 0;
        m_gap = 1;
      end
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit r, output bit acc);
    bit rdy, sh;
    @(negedge clk);
    ivalid = v; isof = s; iready = r;
    #1;
    rdy = m_gap ? 1'b0 : (m_inframe ? r : 1'b1);
    acc = v & rdy;
    sh  = acc & (m_inframe | s);
    chk("in_ready", int'(oin_ready), int'(rdy));
    chk("shift_en", int'(oshift_en), int'(sh));
    chk("busy", int'(obusy), int'(m_inframe | m_gap));
    if (oshift_en) shift_cnt++;
    model_step(acc, s);
  endtask

  task automatic send_px(input bit s, input int pct);
    bit acc, v, r;
    int n;
    n = 0;
    acc = 0;
    while (!acc && n < 200) begin
      v = ($urandom_range(99) >= pct);
      r = ($urandom_range(99) >= pct);
      drive(v, s, r, acc);
      n++;
    end
    if (!acc) chk("send_timeout", n, 0);
  endtask

  task automatic send_frame(input int npx, input int pct);
    for (int i = 0; i < npx; i++) send_px(i == 0, pct);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 0; ivalid = 0; isof = 0; iready = 0;
    repeat (n) @(negedge clk);
    rst_n = 1;
    m_inframe = 0; m_gap = 0; m_cnt = 0; m_p = 0;
    #1;
    chk("rst_win_valid", int'(owin_valid), 0);
    chk("rst_center_x", int'(ocenter_x), 0);
    chk("rst_center_y", int'(ocenter_y), 0);
    chk("rst_frame_done", int'(oframe_done), 0);
    chk("rst_err", int'(oerr), 0);
    chk("rst_win_cnt", int'(owin_cnt), 0);
    chk("rst_busy", int'(obusy), 0);
  endtask

  initial begin
    bit acc;
    bit s;
    rst_n = 0; ivalid = 0; isof = 0; iready = 0;
    do_reset(2);
    mon_en = 1;

    // pixels without start-of-frame while idle are dropped
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, acc);

    // back-to-back frame, then a frame with random stalls
    send_frame(W * H, 0);
    shift_cnt = 0;
    send_frame(W * H, 35);
    chk("stall_shift_count", shift_cnt, W * H);

    // restart error at pixel 40, then a full frame from the restart pixel
    send_frame(40, 10);
    send_frame(W * H, 10);

    // reset mid-frame after 70 pixels, then a clean frame
    send_frame(70, 0);
    do_reset(1);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, acc);
    send_frame(W * H, 20);

    // free-running random stream
    for (int i = 0; i < 1500; i++) begin
      s = m_inframe ? ($urandom_range(999) < 3) : ($urandom_range(99) < 30);
      drive($urandom_range(99) < 70, s, $urandom_range(99) < 75, acc);
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, acc);
    chk("pending_events", wq.size() + dq.size() + eq.size(), 0);

    for (int i = 0; i < 1000 && !done7; i++) @(negedge clk);
    chk("small_frame_finished", int'(done7), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // 7x7 frame: exactly one window, one cycle after the last pixel
  initial begin
    int n7, w_at, d_at, cx, cy, cnt;
    n7 = 0; w_at = -1; d_at = -1; cx = -1; cy = -1; cnt = -1;
    rst7_n = 0; v7 = 0; s7 = 0; r7 = 1;
    repeat (2) @(negedge clk);
    rst7_n = 1;
    for (int i = 0; i < 53; i++) begin
      @(negedge clk);
      if (wv7) begin
        n7++; w_at = i; cx = int'(cx7o); cy = int'(cy7o); cnt = int'(cnt7o);
      end
      if (fd7) d_at = i;
      v7 = (i < 49);
      s7 = (i == 0);
    end
    v7 = 0;
    chk("w7_count", n7, sift_win_pkg::windows_per_frame(7, 7, 7));
    chk("w7_latency", w_at, 49);
    chk("w7_center_x", cx, 3);
    chk("w7_center_y", cy, 3);
    chk("w7_win_cnt", cnt, 1);
    chk("w7_done_at", d_at, 49);
    done7 = 1;
  end

endmodule
